desired_drive_pipe: RTL and testbench
=====================================

Name: desired_drive_pipe

Overview:
Parametrised successor of the eBike assist-current calculator. Converts filtered pedal torque, cadence, incline and the rider assist level into a motor target current through a valid-qualified 3-stage multiply pipeline. A 4th stage adds a slew-rate limiter, so commanded current ramps rather than steps. Sits between the sensor-conditioning block and the brushless-drive PI controller.

Parameters:
TORQUE_W, 12, width of avg_torque
TORQUE_MIN, 12'h380, torque offset subtracted before assist; unsigned, TORQUE_W bits
CURR_W, 12, width of target_curr
PROD_SHIFT, 15, right shift applied to the full product before saturation
SLEW_UP, 64, maximum increase of target_curr per accepted sample
SLEW_DN, 128, maximum decrease of target_curr per accepted sample

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_vld  in  1  input sample strobe; all inputs are sampled when high
avg_torque  in  TORQUE_W  filtered torque, unsigned
cadence  in  5  cadence, unsigned
not_pedaling  in  1  rider not pedaling; forces the raw target to 0
incline  in  13  incline, signed two's complement
scale  in  3  assist level, 0 = off
target_curr  out  CURR_W  slew-limited target current
out_vld  out  1  one-cycle pulse when target_curr updates

Behaviour:
- Reset, asynchronous and immediate: target_curr=0, out_vld=0, all stage valids=0, all pipeline data=0. A reset mid-operation drops every in-flight sample.
- No backpressure. Accepts in_vld on any cycle, including back-to-back. Each stage register loads only when its valid is set; otherwise it holds.
- Stage 1, registered when in_vld=1:
  - incline_sat = incline clamped to signed 10 bits, range [-512, 511].
  - incline_lim = incline_sat + 256, clamped to [0, 511]. 9 bits.
  - cadence_factor = (cadence > 1) ? cadence + 32 : 0. 6 bits.
  - torque_pos = avg_torque - TORQUE_MIN, clamped at 0. TORQUE_W bits.
  - not_pedaling is carried forward with the sample.
- Stage 2:
  - mult1 = torque_pos * scale, TORQUE_W+3 bits.
  - mult2 = incline_lim * cadence_factor, 15 bits.
- Stage 3:
  - prod = mult1 * mult2, TORQUE_W+18 bits, full width, no truncation.
  - raw = not_pedaling ? 0 : sat(prod >> PROD_SHIFT, CURR_W). If any bit of the shifted product above CURR_W-1 is set, raw is all ones.
- Stage 4, slew limiter, updates only when the stage-3 valid is set:
  - raw > cur: cur += min(SLEW_UP, raw - cur).
  - raw < cur: cur -= min(SLEW_DN, cur - raw).
  - raw == cur: hold.
  - target_curr = cur. Never wraps; the min() guarantees the result lands exactly on raw without overshoot.
- Latency: in_vld at cycle N produces out_vld at cycle N+4, with the updated target_curr visible on the same cycle. Throughput is 1 sample/clk.
- Boundaries:
  - A step of exactly SLEW_UP lands in one sample.
  - With SLEW_UP >= 2^CURR_W-1 the limiter is transparent.
  - scale=0 drives raw=0 and target_curr ramps down at SLEW_DN.
  - not_pedaling ramps down the same way; it never causes an instant drop to zero.

Decomposition:
- Package desired_drive_pkg holds:
  - the default TORQUE_MIN constant;
  - incline saturation limits (-512, 511) and offset 256;
  - the cadence threshold (1) and cadence offset (32);
  - a sat_unsigned function used by stages 1 and 3.
- Reuse the existing incline_sat for the 13-to-10-bit clamp.
- One new sub-module, curr_slew_lim, implements stage 4 and is parametrised by CURR_W, SLEW_UP and SLEW_DN.
- Expected RTL size about 150-220 lines in total.

Test Plan:
- Zero-torque case: avg_torque=0x380, scale=4, cadence=16, incline=0, single in_vld -> out_vld at +4 clk, target_curr=0.
- Nominal case with SLEW_UP=4095: avg_torque=0x780, scale=4, cadence=16, incline=0 gives mult1=4096, mult2=12288, raw=0x600 -> target_curr=0x600 on the first out_vld.
- Ramp-up with default SLEW_UP=64, same stimulus as nominal, in_vld every cycle -> target_curr steps 64, 128, ..., 0x600, reaching it on the 24th out_vld, then holds.
- Ramp-down: from a steady 0x600, assert not_pedaling -> target_curr falls by 128 per out_vld and reaches 0 after 12 samples.
- Saturation and clamps:
  - avg_torque=0xFFF, scale=7, cadence=31, incline=13'h0FFF -> target saturates at 0xFFF (with the limiter transparent).
  - incline=-4096 -> incline_lim=0 -> raw=0.
  - cadence=1 -> raw=0.
- Reset mid-pipe: assert rst asynchronously, between clock edges, while 3 samples are in flight -> target_curr=0 and out_vld=0 immediately, and no stale out_vld pulse after rst releases.

Source files
------------

// File: rtl/desired_drive_pkg.sv
// Shared constants and helpers for the desired-drive (assist current) pipeline.
//   TORQUE_MIN_DEF      : default torque offset removed before assist
//   INCL_SAT_MIN/MAX    : signed 10-bit incline clamp limits
//   INCL_OFFSET         : bias that moves the clamped incline into [0, 511]
//   CAD_THRESH/OFFSET   : cadence dead-band threshold and additive offset
//   sat_unsigned()      : clamp a signed value into an unsigned w-bit range
package desired_drive_pkg;

  localparam logic [11:0] TORQUE_MIN_DEF = 12'h380;

  localparam int INCL_SAT_MIN = -512;
  localparam int INCL_SAT_MAX = 511;
  localparam int INCL_OFFSET  = 256;

  localparam int CAD_THRESH = 1;
  localparam int CAD_OFFSET = 32;

  // Negative values clamp to 0, values >= 2^w clamp to all ones.
  function automatic logic [63:0] sat_unsigned(input longint val, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    if (val < 0) begin
      return '0;
    end else if ($unsigned(val) > max_v) begin
      return max_v;
    end
    return $unsigned(val);
  endfunction

endpackage

// File: rtl/curr_slew_lim.sv
// Slew-rate limiter for the target current. On each valid sample the held
// current moves toward i_raw by at most SLEW_UP (rising) or SLEW_DN (falling),
// landing exactly on i_raw when the remaining distance is within the limit.
//   clk, rst : clock, asynchronous active-high reset
//   i_vld    : sample valid
//   i_raw    : unlimited target current
//   o_curr   : limited target current
//   o_vld    : one-cycle pulse when o_curr updates
module curr_slew_lim #(
  parameter int unsigned CURR_W  = 12,
  parameter int unsigned SLEW_UP = 64,
  parameter int unsigned SLEW_DN = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [CURR_W-1:0] i_raw,
  output logic [CURR_W-1:0] o_curr,
  output logic              o_vld
);

  logic [CURR_W-1:0] r_curr;
  logic              r_vld;
  logic [CURR_W-1:0] w_curr_nxt;
  logic [CURR_W-1:0] w_up_diff;
  logic [CURR_W-1:0] w_dn_diff;

  // Differences are only used in the branch where they cannot wrap; the
  // 32-bit compare lets SLEW_* exceed the CURR_W range (transparent limiter).
  always_comb begin
    w_curr_nxt = r_curr;
    w_up_diff  = i_raw - r_curr;
    w_dn_diff  = r_curr - i_raw;
    if (i_raw > r_curr) begin
      if (32'(w_up_diff) > SLEW_UP) begin
        w_curr_nxt = r_curr + CURR_W'(SLEW_UP);
      end else begin
        w_curr_nxt = i_raw;
      end
    end else if (i_raw < r_curr) begin
      if (32'(w_dn_diff) > SLEW_DN) begin
        w_curr_nxt = r_curr - CURR_W'(SLEW_DN);
      end else begin
        w_curr_nxt = i_raw;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_curr <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_curr <= w_curr_nxt;
      end
    end
  end

  assign o_curr = r_curr;
  assign o_vld  = r_vld;

endmodule

// File: rtl/incline_sat.sv
// Clamps a signed 13-bit incline reading to the signed 10-bit range [-512, 511].
//   i_incline     : signed 13-bit incline
//   o_incline_sat : signed 10-bit clamped incline
module incline_sat
  import desired_drive_pkg::*;
(
  input  logic signed [12:0] i_incline,
  output logic signed [9:0]  o_incline_sat
);

  always_comb begin
    if (i_incline < 13'(INCL_SAT_MIN)) begin
      o_incline_sat = 10'(INCL_SAT_MIN);
    end else if (i_incline > 13'(INCL_SAT_MAX)) begin
      o_incline_sat = 10'(INCL_SAT_MAX);
    end else begin
      o_incline_sat = 10'(i_incline);
    end
  end

endmodule

// File: rtl/desired_drive_pipe.sv
// Assist-current calculator: torque, cadence, incline and assist level are
// turned into a motor target current by a valid-qualified 3-stage multiply
// pipeline followed by a slew-rate limiter. Latency in_vld -> out_vld is 4.
//   clk, rst     : clock, asynchronous active-high reset
//   in_vld       : input sample strobe
//   avg_torque   : filtered torque, unsigned
//   cadence      : cadence, unsigned
//   not_pedaling : forces the raw target to 0
//   incline      : signed incline
//   scale        : assist level, 0 = off
//   target_curr  : slew-limited target current
//   out_vld      : one-cycle pulse when target_curr updates
module desired_drive_pipe
  import desired_drive_pkg::*;
#(
  parameter int unsigned          TORQUE_W   = 12,
  parameter logic [TORQUE_W-1:0]  TORQUE_MIN = TORQUE_W'(TORQUE_MIN_DEF),
  parameter int unsigned          CURR_W     = 12,
  parameter int unsigned          PROD_SHIFT = 15,
  parameter int unsigned          SLEW_UP    = 64,
  parameter int unsigned          SLEW_DN    = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [TORQUE_W-1:0] avg_torque,
  input  logic [4:0]          cadence,
  input  logic                not_pedaling,
  input  logic signed [12:0]  incline,
  input  logic [2:0]          scale,
  output logic [CURR_W-1:0]   target_curr,
  output logic                out_vld
);

  localparam int unsigned M1_W   = TORQUE_W + 3;
  localparam int unsigned PROD_W = TORQUE_W + 18;

  // Stage 1 combinational terms
  logic signed [9:0]    w_incl_sat;
  logic [8:0]           w_incl_lim;
  logic [5:0]           w_cad_f;
  logic [TORQUE_W-1:0]  w_torq_pos;

  // Stage 1 registers
  logic                 r_s1_vld;
  logic [8:0]           r_incl_lim;
  logic [5:0]           r_cad_f;
  logic [TORQUE_W-1:0]  r_torq_pos;
  logic [2:0]           r_scale;
  logic                 r_np1;

  // Stage 2 registers
  logic                 r_s2_vld;
  logic [M1_W-1:0]      r_mult1;
  logic [14:0]          r_mult2;
  logic                 r_np2;

  // Stage 3
  logic [PROD_W-1:0]    w_prod;
  logic [CURR_W-1:0]    w_raw;
  logic                 r_s3_vld;
  logic [CURR_W-1:0]    r_raw;

  incline_sat u_incline_sat (
    .i_incline     (incline),
    .o_incline_sat (w_incl_sat)
  );

  assign w_incl_lim = 9'(sat_unsigned(longint'(w_incl_sat) + longint'(INCL_OFFSET), 9));
  assign w_cad_f    = (cadence > 5'(CAD_THRESH)) ? 6'(cadence) + 6'(CAD_OFFSET) : '0;
  assign w_torq_pos = TORQUE_W'(sat_unsigned(longint'(avg_torque) - longint'(TORQUE_MIN), TORQUE_W));

  // Product is kept full width; saturation happens after the shift.
  assign w_prod = PROD_W'(r_mult1) * PROD_W'(r_mult2);
  assign w_raw  = r_np2 ? '0 : CURR_W'(sat_unsigned(longint'(w_prod >> PROD_SHIFT), CURR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_incl_lim <= '0;
      r_cad_f    <= '0;
      r_torq_pos <= '0;
      r_scale    <= '0;
      r_np1      <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_mult1    <= '0;
      r_mult2    <= '0;
      r_np2      <= 1'b0;
      r_s3_vld   <= 1'b0;
      r_raw      <= '0;
    end else begin
      r_s1_vld <= in_vld;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      if (in_vld) begin
        r_incl_lim <= w_incl_lim;
        r_cad_f    <= w_cad_f;
        r_torq_pos <= w_torq_pos;
        r_scale    <= scale;
        r_np1      <= not_pedaling;
      end
      if (r_s1_vld) begin
        r_mult1 <= M1_W'(r_torq_pos) * M1_W'(r_scale);
        r_mult2 <= 15'(r_incl_lim) * 15'(r_cad_f);
        r_np2   <= r_np1;
      end
      if (r_s2_vld) begin
        r_raw <= w_raw;
      end
    end
  end

  curr_slew_lim #(
    .CURR_W  (CURR_W),
    .SLEW_UP (SLEW_UP),
    .SLEW_DN (SLEW_DN)
  ) u_curr_slew_lim (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_s3_vld),
    .i_raw  (r_raw),
    .o_curr (target_curr),
    .o_vld  (out_vld)
  );

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Bench for desired_drive_pipe: one default instance (slew 64/128) and one
// with a transparent limiter, driven with identical stimulus.
module tb_desired_drive_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_vld;
  logic [11:0]        avg_torque;
  logic [4:0]         cadence;
  logic               not_pedaling;
  logic signed [12:0] incline;
  logic [2:0]         scale;
  logic [11:0]        tc_d, tc_t;
  logic               ov_d, ov_t;

  always #5 clk = ~clk;

  desired_drive_pipe dut_d (
    .clk(clk), .rst(rst), .in_vld(in_vld), .avg_torque(avg_torque),
    .cadence(cadence), .not_pedaling(not_pedaling), .incline(incline),
    .scale(scale), .target_curr(tc_d), .out_vld(ov_d)
  );

  desired_drive_pipe #(.SLEW_UP(4095), .SLEW_DN(4095)) dut_t (
    .clk(clk), .rst(rst), .in_vld(in_vld), .avg_torque(avg_torque),
    .cadence(cadence), .not_pedaling(not_pedaling), .incline(incline),
    .scale(scale), .target_curr(tc_t), .out_vld(ov_t)
  );

  typedef struct {
    logic [11:0]        torque;
    logic [4:0]         cad;
    logic               np;
    logic signed [12:0] incl;
    logic [2:0]         scale;
    int                 exp_raw;
    string              name;
  } vec_t;

  typedef struct {
    int due;
    int raw;
    int exp_t;
  } pend_t;

  vec_t  tbl[12];
  pend_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    cur_d = 0;
  int    cur_t = 0;
  int    pulses = 0;
  int    pulse_tgt[64];

  // Reference: the specification's arithmetic in plain integers.
  function automatic int raw_model(int torque, int cad, int np, int incl, int scl);
    int isat, ilim, cf, tp;
    longint prod, sh;
    isat = (incl < -512) ? -512 : ((incl > 511) ? 511 : incl);
    ilim = isat + 256;
    if (ilim < 0) ilim = 0;
    if (ilim > 511) ilim = 511;
    cf = (cad > 1) ? cad + 32 : 0;
    tp = (torque > 'h380) ? torque - 'h380 : 0;
    prod = longint'(tp) * scl * ilim * cf;
    sh = prod >> 15;
    if (np != 0) return 0;
    return (sh > 4095) ? 4095 : int'(sh);
  endfunction

  function automatic int slew(int cur, int raw, int up, int dn);
    if (raw > cur) return cur + ((raw - cur < up) ? raw - cur : up);
    if (raw < cur) return cur - ((cur - raw < dn) ? cur - raw : dn);
    return cur;
  endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check();
    pend_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      cur_d = slew(cur_d, e.raw, 64, 128);
      cur_t = e.exp_t;
      cmp("out_vld_def", ov_d, 1);
      cmp("out_vld_trn", ov_t, 1);
      cmp("target_def", tc_d, cur_d);
      cmp("target_trn", tc_t, cur_t);
      pulses++;
      if (pulses < 64) pulse_tgt[pulses] = int'(tc_d);
    end else begin
      cmp("idle_vld_def", ov_d, 0);
      cmp("idle_vld_trn", ov_t, 0);
    end
  endtask

  task automatic drive(input logic vld, input logic [11:0] tq, input logic [4:0] cd,
                       input logic np, input logic signed [12:0] inc, input logic [2:0] sc,
                       input int exp_t, input logic use_exp);
    int r;
    in_vld = vld; avg_torque = tq; cadence = cd; not_pedaling = np; incline = inc; scale = sc;
    if (vld) begin
      r = raw_model(int'(tq), int'(cd), int'(np), int'(inc), int'(sc));
      q.push_back('{cyc + 4, r, use_exp ? exp_t : r});
    end
    tick();
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'h0, 5'd0, 1'b0, 13'sd0, 3'd0, 0, 1'b0);
  endtask

  task automatic nominal(input logic np);
    drive(1'b1, 12'h780, 5'd16, np, 13'sd0, 3'd4, 0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    in_vld = 1'b0;
    tick();
    #2 rst = 1'b0;
    q.delete();
    cur_d = 0;
    cur_t = 0;
  endtask

  initial begin
    rst = 1'b1;
    in_vld = 1'b0; avg_torque = '0; cadence = '0; not_pedaling = 1'b0; incline = '0; scale = '0;
    tbl[0]  = '{12'h380, 5'd16, 1'b0, 13'sd0,    3'd4, 0,     "zero_torque"};
    tbl[1]  = '{12'h780, 5'd16, 1'b0, 13'sd0,    3'd4, 'h600, "nominal"};
    tbl[2]  = '{12'hFFF, 5'd31, 1'b0, 13'h0FFF,  3'd7, 'hFFF, "saturate"};
    tbl[3]  = '{12'h780, 5'd16, 1'b0, 13'h1000,  3'd4, 0,     "incline_min"};
    tbl[4]  = '{12'h780, 5'd1,  1'b0, 13'sd0,    3'd4, 0,     "cadence_1"};
    tbl[5]  = '{12'h780, 5'd2,  1'b0, 13'sd0,    3'd4, 1088,  "cadence_2"};
    tbl[6]  = '{12'h780, 5'd16, 1'b0, 13'sd0,    3'd0, 0,     "scale_0"};
    tbl[7]  = '{12'h780, 5'd16, 1'b1, 13'sd0,    3'd4, 0,     "not_pedaling"};
    tbl[8]  = '{12'h780, 5'd16, 1'b0, -13'sd256, 3'd4, 0,     "incline_m256"};
    tbl[9]  = '{12'h780, 5'd16, 1'b0, -13'sd255, 3'd4, 6,     "incline_m255"};
    tbl[10] = '{12'h780, 5'd16, 1'b0, 13'sd511,  3'd4, 3066,  "incline_511"};
    tbl[11] = '{12'h37F, 5'd16, 1'b0, 13'sd0,    3'd4, 0,     "torque_below_min"};

    // Reset state
    tick(); tick();
    cmp("rst_vld_def", ov_d, 0);
    cmp("rst_vld_trn", ov_t, 0);
    cmp("rst_tgt_def", tc_d, 0);
    cmp("rst_tgt_trn", tc_t, 0);
    #2 rst = 1'b0;
    idle(2);

    // Table: first sample alone to check the +4 latency, rest back-to-back
    drive(1'b1, tbl[0].torque, tbl[0].cad, tbl[0].np, tbl[0].incl, tbl[0].scale, tbl[0].exp_raw, 1'b1);
    idle(5);
    for (int i = 1; i < 12; i++)
      drive(1'b1, tbl[i].torque, tbl[i].cad, tbl[i].np, tbl[i].incl, tbl[i].scale, tbl[i].exp_raw, 1'b1);
    idle(6);

    // Ramp-up from zero
    do_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) nominal(1'b0);
    idle(6);
    cmp("ramp_first", pulse_tgt[1], 64);
    cmp("ramp_23rd", pulse_tgt[23], 'h5C0);
    cmp("ramp_24th", pulse_tgt[24], 'h600);
    cmp("ramp_hold", tc_d, 'h600);

    // Ramp-down via not_pedaling
    pulses = 0;
    for (int i = 0; i < 12; i++) nominal(1'b1);
    idle(6);
    cmp("down_first", pulse_tgt[1], 'h600 - 128);
    cmp("down_11th", pulse_tgt[11], 128);
    cmp("down_12th", pulse_tgt[12], 0);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0),
            12'($urandom_range('h300, 'hFFF)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0), 13'($urandom), 3'($urandom_range(0, 7)),
            0, 1'b0);
    end
    idle(6);

    // Asynchronous reset with three samples in flight
    do_reset();
    for (int i = 0; i < 30; i++) nominal(1'b0);
    cmp("pre_rst_tgt", tc_d, 'h600);
    #3 rst = 1'b1;
    #1;
    cmp("async_rst_tgt_def", tc_d, 0);
    cmp("async_rst_vld_def", ov_d, 0);
    cmp("async_rst_tgt_trn", tc_t, 0);
    cmp("async_rst_vld_trn", ov_t, 0);
    q.delete();
    cur_d = 0;
    cur_t = 0;
    in_vld = 1'b0;
    tick();
    #2 rst = 1'b0;
    idle(8);
    cmp("post_rst_tgt", tc_d, 0);

    if (q.size() != 0) cmp("pending_samples", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
